// File: rtl/add_sub_32_if.sv
// Operand/result bundle for the registered 32-bit adder/subtractor.
// master drives A/B/SEL and reads OUT/carry; slave is the adder side.
interface add_sub_32_if;
  logic [31:0] A;
  logic [31:0] B;
  logic        SEL;
  logic [31:0] OUT;
  logic        carry;

  modport master (
    output A,
    output B,
    output SEL,
    input  OUT,
    input  carry
  );

  modport slave (
    input  A,
    input  B,
    input  SEL,
    output OUT,
    output carry
  );
endinterface

// File: rtl/add_sub_32.sv
// Registered 32-bit adder/subtractor: OUT/carry <= A + (SEL ? ~B : B) + SEL.
// Ports: clk, rst_n (async, active-low), bus (slave: A, B, SEL -> OUT, carry).
// Macro ADD32_CLA_EN selects a block carry-lookahead core (CLA_BLOCK bits
// per group); when undefined the core is a ripple-carry chain.
module add_sub_32 #(
  parameter int WIDTH     = 32,
  parameter int CLA_BLOCK = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  add_sub_32_if.slave  bus
);

  if ((WIDTH != 32) || ((WIDTH % CLA_BLOCK) != 0)) begin : g_bad_cfg
    $error("add_sub_32: WIDTH must be 32 and a multiple of CLA_BLOCK");
  end

  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] bx;
  logic             cin;
  logic [WIDTH-1:0] s;
  logic             cout;

  // Subtract is A + ~B + 1, so SEL doubles as the carry-in.
  assign a   = bus.A;
  assign cin = bus.SEL;
  assign bx  = bus.SEL ? ~bus.B : bus.B;

`ifdef ADD32_CLA_EN

  localparam int NG = WIDTH / CLA_BLOCK;

  logic [WIDTH-1:0] g;
  logic [WIDTH-1:0] p;
  logic [NG-1:0]    gg;
  logic [NG-1:0]    gp;
  logic [NG:0]      gc;
  logic [WIDTH-1:0] c;

  assign g = a & bx;
  assign p = a ^ bx;

  // Group generate/propagate.
  always_comb begin
    gg = '0;
    gp = '1;
    for (int j = 0; j < NG; j++) begin
      for (int k = 0; k < CLA_BLOCK; k++) begin
        gg[j] = g[j*CLA_BLOCK+k] | (p[j*CLA_BLOCK+k] & gg[j]);
        gp[j] = gp[j] & p[j*CLA_BLOCK+k];
      end
    end
  end

  // Second-level lookahead: every group carry is a flat sum of products
  // of lower group G/P terms and cin, not a chain through gc.
  always_comb begin
    logic t;
    logic pr;
    gc    = '0;
    gc[0] = cin;
    t     = 1'b0;
    pr    = 1'b1;
    for (int j = 0; j < NG; j++) begin
      t  = gg[j];
      pr = gp[j];
      for (int k = j - 1; k >= 0; k--) begin
        t  = t | (pr & gg[k]);
        pr = pr & gp[k];
      end
      gc[j+1] = t | (pr & cin);
    end
  end

  // Bit carries inside each group start from that group's lookahead carry.
  always_comb begin
    c = '0;
    for (int j = 0; j < NG; j++) begin
      c[j*CLA_BLOCK] = gc[j];
      for (int k = 1; k < CLA_BLOCK; k++) begin
        c[j*CLA_BLOCK+k] = g[j*CLA_BLOCK+k-1] |
                           (p[j*CLA_BLOCK+k-1] & c[j*CLA_BLOCK+k-1]);
      end
    end
  end

  assign s    = p ^ c;
  assign cout = gc[NG];

`else

  logic [WIDTH:0] c;

  // Ripple chain of full adders.
  always_comb begin
    c    = '0;
    c[0] = cin;
    s    = '0;
    for (int i = 0; i < WIDTH; i++) begin
      s[i]   = a[i] ^ bx[i] ^ c[i];
      c[i+1] = (a[i] & bx[i]) | (c[i] & (a[i] ^ bx[i]));
    end
  end

  assign cout = c[WIDTH];

`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.OUT   <= '0;
      bus.carry <= 1'b0;
    end else begin
      bus.OUT   <= s;
      bus.carry <= cout;
    end
  end

endmodule

// File: tb/tb_add_sub_32.sv
// Self-checking bench for add_sub_32: directed corners, async reset,
// and random vectors against an arithmetic reference model.
module tb_add_sub_32;

  logic clk;
  logic rst_n;
  int   n_chk;
  int   n_fail;

  add_sub_32_if bus ();

  add_sub_32 dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] e_out,
                     input logic e_c);
    n_chk++;
    assert ({bus.carry, bus.OUT} === {e_c, e_out})
    else begin
      n_fail++;
      $error("FAIL %s: got OUT=%h carry=%b, expected OUT=%h carry=%b",
             tag, bus.OUT, bus.carry, e_out, e_c);
    end
  endtask

  // Reference: plain unsigned arithmetic; carry on subtract is "no borrow".
  task automatic model(input logic [31:0] a, input logic [31:0] b,
                       input logic sel,
                       output logic [31:0] r, output logic c);
    logic [32:0] wide;
    if (!sel) begin
      wide = {1'b0, a} + {1'b0, b};
      r    = wide[31:0];
      c    = wide[32];
    end else begin
      r = a - b;
      c = (a >= b);
    end
  endtask

  task automatic op(input string tag, input logic [31:0] a,
                    input logic [31:0] b, input logic sel);
    logic [31:0] r;
    logic        c;
    bus.A   = a;
    bus.B   = b;
    bus.SEL = sel;
    model(a, b, sel, r, c);
    @(posedge clk);
    #1;
    chk(tag, r, c);
  endtask

  initial begin
    logic [31:0] ra;
    logic [31:0] rb;
    logic        rs;
    n_chk   = 0;
    n_fail  = 0;
    bus.A   = '0;
    bus.B   = '0;
    bus.SEL = 1'b0;
    rst_n   = 1'b1;
    #1;
    rst_n   = 1'b0;
    #1;
    chk("reset_init", 32'h0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    op("add_0_10",     32'h0000_0000, 32'h0000_0010, 1'b0);
    chk("add_0_10_k",  32'h0000_0010, 1'b0);
    op("add_10_10",    32'h0000_0010, 32'h0000_0010, 1'b0);
    chk("add_10_10_k", 32'h0000_0020, 1'b0);
    op("sub_borrow",   32'h0000_0000, 32'h0000_0010, 1'b1);
    chk("sub_borrow_k", 32'hFFFF_FFF0, 1'b0);
    op("sub_noborrow", 32'h0000_0100, 32'h0000_0010, 1'b1);
    chk("sub_nb_k",    32'h0000_00F0, 1'b1);
    op("sub_equal",    32'h0000_0010, 32'h0000_0010, 1'b1);
    chk("sub_equal_k", 32'h0000_0000, 1'b1);
    op("add_ovf",      32'hFFFF_FFFF, 32'h0000_0001, 1'b0);
    chk("add_ovf_k",   32'h0000_0000, 1'b1);
    op("add_msb",      32'h8000_0000, 32'h8000_0000, 1'b0);
    chk("add_msb_k",   32'h0000_0000, 1'b1);
    op("sub_zero",     32'h0000_0000, 32'h0000_0000, 1'b1);
    op("sub_ones",     32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
    op("add_zero",     32'h0000_0000, 32'h0000_0000, 1'b0);
    op("add_ones",     32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    op("sub_0_1",      32'h0000_0000, 32'h0000_0001, 1'b1);
    op("add_alt",      32'hAAAA_AAAA, 32'h5555_5555, 1'b0);
    op("add_alt_c",    32'hAAAA_AAAB, 32'h5555_5555, 1'b0);

    // Reset between edges clears the registers at once.
    bus.A   = 32'h0000_0010;
    bus.B   = 32'h0000_0010;
    bus.SEL = 1'b0;
    @(posedge clk);
    #1;
    chk("pre_reset", 32'h0000_0020, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("reset_async", 32'h0, 1'b0);
    @(posedge clk);
    #1;
    chk("reset_held", 32'h0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("reset_release", 32'h0, 1'b0);
    @(posedge clk);
    #1;
    chk("post_reset", 32'h0000_0020, 1'b0);

    for (int i = 0; i < 10000; i++) begin
      ra = $urandom;
      rb = $urandom;
      rs = 1'($urandom_range(0, 1));
      op("random", ra, rb, rs);
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
